// File: rtl/program_loader.sv
// Streams segmented program images (header + data words) into instruction memory,
// then hands control to the CPU once an end marker arrives.
module program_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              reload,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              w_enable,
  output logic [ADDR_W-1:0] w_adrs,
  output logic [DATA_W-1:0] w_instruction,
  output logic              cpu_en,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, HDR, DATA, RUN, ERR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] adrs;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] hdr_base;
  logic [ADDR_W-1:0] hdr_len;
  logic [ADDR_W:0]   hdr_end;
  logic              accept;

  assign hdr_base = s_data[ADDR_W-1:0];
  assign hdr_len  = s_data[2*ADDR_W-1:ADDR_W];
  // One extra bit so a segment ending exactly at the top of memory is representable.
  assign hdr_end  = {1'b0, hdr_base} + {1'b0, hdr_len};

  assign s_ready = (state == HDR) || (state == DATA);
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      adrs          <= '0;
      remaining     <= '0;
      w_enable      <= 1'b0;
      w_adrs        <= '0;
      w_instruction <= '0;
      cpu_en        <= 1'b0;
      error         <= 1'b0;
      words_loaded  <= '0;
    end else begin
      w_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= HDR;
            error        <= 1'b0;
            words_loaded <= '0;
          end
        end

        HDR: begin
          if (accept) begin
            if (hdr_len == '0) begin
              state  <= RUN;
              cpu_en <= 1'b1;
            end else if (hdr_end > DEPTH) begin
              state <= ERR;
              error <= 1'b1;
            end else begin
              state     <= DATA;
              adrs      <= hdr_base;
              remaining <= hdr_len;
            end
          end
        end

        DATA: begin
          if (accept) begin
            w_enable      <= 1'b1;
            w_adrs        <= adrs;
            w_instruction <= s_data;
            adrs          <= adrs + ADDR_ONE;
            remaining     <= remaining - ADDR_ONE;
            words_loaded  <= words_loaded + COUNT_ONE;
            if (remaining == ADDR_ONE) begin
              state <= HDR;
            end
          end
        end

        RUN: begin
          if (reload) begin
            state        <= HDR;
            cpu_en       <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
          end
        end

        ERR: begin
          if (start || reload) begin
            state        <= HDR;
            error        <= 1'b0;
            words_loaded <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The module SHALL take parameter DATA_W, default 32, meaning the width of stream and memory data words.
REQ-002 The module SHALL take parameter ADDR_W, default 11, meaning the width of the memory address, so DEPTH = 2**ADDR_W; DATA_W SHALL be at least 2*ADDR_W.
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begin a load session from IDLE or ERR.
- reload  in  1  pulse; drop the CPU and begin a new session from RUN or ERR.
- s_valid  in  1  stream word valid.
- s_ready  out  1  stream word accepted when s_valid and s_ready are both high.
- s_data  in  DATA_W  stream word.
- w_enable  out  1  memory write strobe.
- w_adrs  out  ADDR_W  memory write address.
- w_instruction  out  DATA_W  memory write data.
- cpu_en  out  1  CPU run enable.
- error  out  1  sticky segment-range error.
- words_loaded  out  ADDR_W+1  count of data words written this session.

Function
REQ-010 The module SHALL implement FSM states IDLE, HDR, DATA, RUN and ERR.
REQ-011 In HDR, the accepted word SHALL be a segment header with the following fields.
- base = s_data[ADDR_W-1:0].
- len = s_data[2*ADDR_W-1:ADDR_W].
- All other bits ignored.
REQ-012 From HDR, a header with len=0 SHALL be the end marker and move the FSM to RUN.
REQ-013 From HDR, a header with len>0 and base+len <= DEPTH SHALL move the FSM to DATA, with the write address set to base and the remaining count set to len.
- The sum base+len SHALL be computed in ADDR_W+1 bits.
REQ-014 From HDR, a header with base+len > DEPTH SHALL move the FSM to ERR and set error=1, and no memory write SHALL occur for that segment.
REQ-015 In DATA, each accepted word SHALL be written to the current address, after which the address increments by 1, remaining decrements by 1, and words_loaded increments by 1.
REQ-016 When the final word of a segment (remaining=1) is accepted, the FSM SHALL return to HDR.
REQ-017 The write SHALL be registered: a word accepted in cycle N SHALL appear as w_enable=1 with its w_adrs/w_instruction in cycle N+1 only.
- w_enable SHALL be 0 in all other cycles.
REQ-018 s_ready SHALL be 1 exactly in HDR and DATA, and 0 in IDLE, RUN and ERR.
- s_ready SHALL not depend combinationally on s_valid.
REQ-019 Cycles with s_valid=0 SHALL cause no state, address or count change.
REQ-020 cpu_en SHALL be 1 exactly while the FSM is in RUN.
- It SHALL rise in the cycle after the end marker is accepted.
- This guarantees the last data write has already completed.
REQ-021 start in IDLE or ERR SHALL move the FSM to HDR, clear error and clear words_loaded.
- start in any other state SHALL be ignored.
REQ-022 reload in RUN or ERR SHALL move the FSM to HDR, drop cpu_en in the next cycle, clear error and clear words_loaded.
- reload in any other state SHALL be ignored.
REQ-023 If start and reload are both asserted in ERR, the single resulting transition to HDR SHALL occur once.
REQ-024 Segments SHALL be allowed to overlap or repeat addresses; the later write wins.
- No read-back occurs.
REQ-025 A segment that ends exactly at address DEPTH-1 SHALL be legal.
- The internal address SHALL then not be used again until the next header.

Reset
REQ-030 While reset=1, the following SHALL hold regardless of clk:
- FSM=IDLE.
- s_ready=0, w_enable=0, w_adrs=0, w_instruction=0.
- cpu_en=0, error=0, words_loaded=0.
REQ-031 Reset asserted mid-DATA SHALL abandon the segment.
- A write accepted in the cycle of reset assertion SHALL NOT be issued.
REQ-032 After reset deassertion, the module SHALL stay in IDLE until start.

Verification
REQ-040 The bench SHALL cover a basic load.
- Stimulus: start; stream header(base=1,len=2), 0xE0060064, 0xE0C00065, header(base=100,len=2), 10, 11, header(len=0).
- Response: writes (1,0xE0060064), (2,0xE0C00065), (100,10), (101,11) in order, each one cycle after acceptance; words_loaded=4; cpu_en=1 one cycle after the end marker; s_ready=0 from then on.
REQ-041 The bench SHALL cover backpressure and gaps.
- Stimulus: the same stream with s_valid toggled 1,0,0,1.
- Response: identical write sequence, with no duplicate or skipped address.
REQ-042 The bench SHALL cover the range boundary.
- Stimulus: header(base=2040,len=8) followed by 8 words.
- Response: writes to 2040..2047 and no error.
- Stimulus: header(base=2041,len=8).
- Response: error=1, FSM in ERR, s_ready=0, no w_enable.
- Stimulus: then start.
- Response: error=0 and HDR.
REQ-043 The bench SHALL cover reset mid-segment.
- Stimulus: header(base=5,len=4), accept 2 words, assert reset.
- Response: all outputs at reset values and no further writes.
- Stimulus: after release, a word with s_valid=1 but no start.
- Response: ignored.
REQ-044 The bench SHALL cover reload from RUN.
- Stimulus: reach RUN, pulse reload.
- Response: cpu_en=0 next cycle, words_loaded=0, s_ready=1.
- Stimulus: new segment(base=10,len=1,data=0) and end marker.
- Response: a single write (10,0), then cpu_en=1.
REQ-045 The bench SHALL cover ignored controls.
- Stimulus: start during DATA, and reload during HDR.
- Response: no state change and the segment completes normally.
